// File: rtl/full_adder_pkg.sv
// Shared constants and the pipeline beat record for the clocked 1-bit full adder.
package full_adder_pkg;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  typedef struct packed {
    logic valid;
    logic sum;
    logic cout;
  } fa_beat_t;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder: sum and majority carry of a, b and ci.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/full_adder_1bit_behavioral.sv
// Clocked 1-bit full adder with an optional serial carry register and a
// LATENCY-deep result pipeline for LSB-first bit-serial addition.
module full_adder_1bit_behavioral
  import full_adder_pkg::*;
#(
  parameter int LATENCY   = 1,
  parameter bit SERIAL_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic carry_sel,
  input  logic carry_clr,
  output logic out_valid,
  output logic sum,
  output logic cout,
  output logic carry_q
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("full_adder_1bit_behavioral: LATENCY %0d outside %0d..%0d",
           LATENCY, LATENCY_MIN, LATENCY_MAX);
  end

  logic     ci;
  logic     s;
  logic     co;
  fa_beat_t beat_d;
  fa_beat_t pipe_d [LATENCY];
  fa_beat_t pipe_q [LATENCY];

  // Clear beats everything, then the fed-back carry, then the external carry.
  always_comb begin
    ci = cin;
    if (carry_clr) begin
      ci = 1'b0;
    end else if (SERIAL_EN && carry_sel) begin
      ci = carry_q;
    end
  end

  full_adder_cell u_cell (
    .a  (a),
    .b  (b),
    .ci (ci),
    .s  (s),
    .co (co)
  );

  always_comb begin
    beat_d = '0;
    if (in_valid) begin
      beat_d.valid = 1'b1;
      beat_d.sum   = s;
      beat_d.cout  = co;
    end
  end

  if (SERIAL_EN) begin : g_serial
    logic carry_d;

    // The carry updates at the sampling edge so the next serial beat sees it,
    // regardless of how deep the result pipeline is.
    always_comb begin
      carry_d = carry_q;
      if (in_valid) begin
        carry_d = co;
      end else if (carry_clr) begin
        carry_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        carry_q <= 1'b0;
      end else begin
        carry_q <= carry_d;
      end
    end
  end else begin : g_no_serial
    assign carry_q = 1'b0;
  end

  for (genvar i = 0; i < LATENCY; i++) begin : g_pipe
    if (i == 0) begin : g_head
      assign pipe_d[i] = beat_d;
    end else begin : g_tail
      assign pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage boundary: every stage advances each cycle; bubbles carry zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign out_valid = pipe_q[LATENCY-1].valid;
  assign sum       = pipe_q[LATENCY-1].sum;
  assign cout      = pipe_q[LATENCY-1].cout;

endmodule

// File: tb/tb_full_adder_1bit_behavioral.sv
// Bench for full_adder_1bit_behavioral: four latencies plus a non-serial copy
// driven in parallel, checked against tables and an arithmetic reference model.
module tb_full_adder_1bit_behavioral;

  typedef struct packed {
    logic v;
    logic s;
    logic c;
  } exp_t;

  typedef struct packed {
    logic v, a, b, cin, sel, clr;
    logic es, ec, ecq;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, a = 1'b0, b = 1'b0, cin = 1'b0;
  logic carry_sel = 1'b0, carry_clr = 1'b0;

  logic [4:1] ov, sm, co, cq;
  logic ov0, sm0, co0, cq0;

  always #5 clk = ~clk;

  for (genvar l = 1; l <= 4; l++) begin : g_dut
    full_adder_1bit_behavioral #(.LATENCY(l), .SERIAL_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
      .carry_sel(carry_sel), .carry_clr(carry_clr),
      .out_valid(ov[l]), .sum(sm[l]), .cout(co[l]), .carry_q(cq[l])
    );
  end

  full_adder_1bit_behavioral #(.LATENCY(2), .SERIAL_EN(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .carry_sel(carry_sel), .carry_clr(carry_clr),
    .out_valid(ov0), .sum(sm0), .cout(co0), .carry_q(cq0)
  );

  // Reference model state: per-edge results, stored carry, reset boundary.
  exp_t hist  [0:2047];
  exp_t hist0 [0:2047];
  int   nedge = 0;
  int   rst_edge = 0;
  logic mc = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, nedge, act, exp);
    end
  endtask

  task automatic check_model();
    exp_t e;
    for (int l = 1; l <= 4; l++) begin
      int idx = nedge - l;
      e = (idx >= rst_edge) ? hist[idx] : '0;
      chk($sformatf("lat%0d {valid,sum,cout}", l), {ov[l], sm[l], co[l]}, e);
      chk($sformatf("lat%0d carry_q", l), {2'b00, cq[l]}, {2'b00, mc});
    end
    begin
      int idx0 = nedge - 2;
      e = (idx0 >= rst_edge) ? hist0[idx0] : '0;
      chk("noserial {valid,sum,cout}", {ov0, sm0, co0}, e);
      chk("noserial carry_q", {2'b00, cq0}, 3'b000);
    end
  endtask

  // Drive one beat, clock it, advance the model, then check every instance.
  task automatic apply(input logic v, input logic ia, input logic ib,
                       input logic icin, input logic isel, input logic iclr);
    int   tot, tot0;
    logic ci, ci0;
    in_valid = v; a = ia; b = ib; cin = icin; carry_sel = isel; carry_clr = iclr;
    ci   = iclr ? 1'b0 : (isel ? mc : icin);
    ci0  = iclr ? 1'b0 : icin;
    tot  = int'(ia) + int'(ib) + int'(ci);
    tot0 = int'(ia) + int'(ib) + int'(ci0);
    @(posedge clk);
    hist[nedge]  = v ? exp_t'{1'b1, tot[0] == 1'b1, tot >= 2} : '0;
    hist0[nedge] = v ? exp_t'{1'b1, tot0[0] == 1'b1, tot0 >= 2} : '0;
    if (v) mc = (tot >= 2);
    else if (iclr) mc = 1'b0;
    nedge++;
    #1;
    check_model();
  endtask

  vec_t tbl [16];

  initial begin
    // Truth table rows (carry_sel = 0), then serial 1011 + 0110 LSB-first,
    // then clear priority: set carry_q = 1, then clr beat with carry_sel = 1.
    tbl[0]  = '{1,0,0,0,0,0, 0,0,0};
    tbl[1]  = '{1,1,1,1,0,0, 1,1,1};
    tbl[2]  = '{1,1,1,0,0,0, 0,1,1};
    tbl[3]  = '{1,0,1,1,0,0, 0,1,1};
    tbl[4]  = '{1,1,0,0,1,1, 1,0,0};
    tbl[5]  = '{1,1,1,0,1,0, 0,1,1};
    tbl[6]  = '{1,0,1,0,1,0, 0,1,1};
    tbl[7]  = '{1,1,0,0,1,0, 0,1,1};
    tbl[8]  = '{1,1,1,0,0,0, 0,1,1};
    tbl[9]  = '{1,1,0,0,1,1, 1,0,0};
    tbl[10] = '{1,1,1,0,0,0, 0,1,1};
    tbl[11] = '{0,0,0,0,0,0, 0,0,1};
    tbl[12] = '{1,0,0,0,1,0, 1,0,0};
    tbl[13] = '{1,0,0,0,0,1, 0,0,0};
    tbl[14] = '{0,1,1,1,1,1, 0,0,0};
    tbl[15] = '{1,1,0,1,0,0, 0,1,1};

    repeat (2) @(posedge clk);
    #1;
    for (int l = 1; l <= 4; l++) begin
      chk($sformatf("reset lat%0d", l), {ov[l], sm[l], co[l]}, 3'b000);
      chk($sformatf("reset carry_q lat%0d", l), {2'b00, cq[l]}, 3'b000);
    end
    chk("reset noserial", {ov0, sm0, co0}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sel, tbl[i].clr);
      chk($sformatf("table[%0d] lat1 {valid,sum,cout}", i), {ov[1], sm[1], co[1]},
          tbl[i].v ? {1'b1, tbl[i].es, tbl[i].ec} : 3'b000);
      chk($sformatf("table[%0d] carry_q", i), {2'b00, cq[1]}, {2'b00, tbl[i].ecq});
    end

    // Exhaustive sweep of a,b,cin with carry_sel = 0 through all latencies.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] abc;
      abc = k[2:0];
      apply(1'b1, abc[2], abc[1], abc[0], 1'b0, 1'b0);
    end
    repeat (4) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bubble pattern 1,0,1 around a live carry.
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bubble keeps carry_q", {2'b00, cq[1]}, 3'b001);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("after bubble lat1", {ov[1], sm[1], co[1]}, 3'b110);

    // Reset with three beats in flight in the LATENCY = 3 copy.
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    for (int l = 1; l <= 4; l++) begin
      chk($sformatf("midreset lat%0d", l), {ov[l], sm[l], co[l]}, 3'b000);
      chk($sformatf("midreset carry_q lat%0d", l), {2'b00, cq[l]}, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mc = 1'b0;
    rst_edge = nedge;
    repeat (5) apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(7) == 0));
    end
    repeat (4) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
